// File: rtl/ask4_symbol_mapper_if.sv
// ---------------------------------------------------------------------------
// ask4_symbol_mapper_if
// Byte handshake and symbol-output bundle for the 4-ASK symbol mapper.
//   data_in    [7:0]  byte to transmit            (master -> slave)
//   data_valid        data_in valid this cycle    (master -> slave)
//   data_ready        slave can take a byte       (slave  -> master)
//   sel        [1:0]  carrier select to the mux   (slave  -> master)
//   sym_strobe        first cycle of each symbol  (slave  -> master)
//   busy              sending or byte waiting     (slave  -> master)
// ---------------------------------------------------------------------------
interface ask4_symbol_mapper_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] sel;
    logic       sym_strobe;
    logic       busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, sel, sym_strobe, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, sel, sym_strobe, busy
    );
endinterface

// File: rtl/ask4_symbol_mapper.sv
// ---------------------------------------------------------------------------
// ask4_symbol_mapper
// Splits each accepted byte into four dibits (MSB pair first) and holds each
// one on sel for SYMBOL_LEN clocks, feeding the 4-ASK carrier multiplexer.
// One byte can wait in a holding register while another is being sent, so a
// continuous stream runs at exactly 4*SYMBOL_LEN clocks per byte, no gaps.
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   slave side of ask4_symbol_mapper_if (byte handshake in,
//         registered sel / sym_strobe out, busy out)
// Parameters:
//   SYMBOL_LEN  clocks per symbol (>= 1)
//   IDLE_SEL    sel value when nothing is being sent
//   GRAY_MAP    0: sel = dibit, 1: sel = {b1, b1^b0}
// ---------------------------------------------------------------------------
module ask4_symbol_mapper #(
    parameter int         SYMBOL_LEN = 16,
    parameter logic [1:0] IDLE_SEL   = 2'b00,
    parameter bit         GRAY_MAP   = 1'b0
) (
    input logic                clk,
    input logic                rst,
    ask4_symbol_mapper_if.slave bus
);

    localparam int            PW       = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(SYMBOL_LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic          hold_full;
    logic [7:0]    hold;
    logic [7:0]    sh;
    logic [PW-1:0] per_cnt;
    logic [1:0]    sym_cnt;
    logic [1:0]    sel_r, sel_nxt;
    logic          strobe_r, strobe_nxt;

    logic          accept;
    logic          load;
    logic          shift;
    logic          per_last;

    function automatic logic [1:0] map_dibit(input logic [1:0] d);
        if (GRAY_MAP)
            return {d[1], d[1] ^ d[0]};
        else
            return d;
    endfunction

    // Ready is forced low during reset so nothing is accepted while rst=1.
    assign bus.data_ready = !hold_full && !rst;
    assign accept         = bus.data_valid && bus.data_ready;
    assign per_last       = (per_cnt == PER_LAST);

    assign bus.sel        = sel_r;
    assign bus.sym_strobe = strobe_r;
    assign bus.busy       = (state == SEND) || hold_full;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hold_full) state_nxt = SEND;
            SEND: if (per_last && sym_cnt == 2'd3 && !hold_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath-control logic: next values for the registered outputs
    // plus the load (hold -> sh) and shift (next dibit) enables.
    always_comb begin
        load       = 1'b0;
        shift      = 1'b0;
        sel_nxt    = sel_r;
        strobe_nxt = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = IDLE_SEL;
                if (hold_full) begin
                    load       = 1'b1;
                    sel_nxt    = map_dibit(hold[7:6]);
                    strobe_nxt = 1'b1;
                end
            end
            SEND: begin
                if (per_last) begin
                    if (sym_cnt != 2'd3) begin
                        shift      = 1'b1;
                        // sh[7:6] is the symbol on air; the next pair sits below it.
                        sel_nxt    = map_dibit(sh[5:4]);
                        strobe_nxt = 1'b1;
                    end else if (hold_full) begin
                        load       = 1'b1;
                        sel_nxt    = map_dibit(hold[7:6]);
                        strobe_nxt = 1'b1;
                    end else begin
                        sel_nxt = IDLE_SEL;
                    end
                end
            end
            default: sel_nxt = IDLE_SEL;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            per_cnt   <= '0;
            sym_cnt   <= 2'd0;
            sel_r     <= IDLE_SEL;
            strobe_r  <= 1'b0;
        end else begin
            // An accept on the same edge as a load keeps the register full.
            if (accept)
                hold_full <= 1'b1;
            else if (load)
                hold_full <= 1'b0;

            if (load || shift)
                per_cnt <= '0;
            else if (state == SEND)
                per_cnt <= per_cnt + PW'(1);

            if (load)
                sym_cnt <= 2'd0;
            else if (shift)
                sym_cnt <= sym_cnt + 2'd1;

            sel_r    <= sel_nxt;
            strobe_r <= strobe_nxt;
        end
    end

    // Data registers: qualified by hold_full / state, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept)
            hold <= bus.data_in;
        if (load)
            sh <= hold;
        else if (shift)
            sh <= {sh[5:0], 2'b00};
    end

endmodule

// File: doc/ask4_symbol_mapper.md
Name: ask4_symbol_mapper

Overview:
- Upstream feeder of the 4-ASK carrier multiplexer.
- Accepts parallel data bytes over a valid/ready handshake and splits each byte into four 2-bit symbols, MSB pair first.
- Each symbol is held on sel for SYMBOL_LEN clocks. sel drives the multiplexer's 2-bit carrier select directly.
- Outputs IDLE_SEL when no data is pending.

Parameters:
SYMBOL_LEN, 16, clocks per symbol; must be >= 1; period counter width is max(1, $clog2(SYMBOL_LEN)).
IDLE_SEL, 2'b00, sel value driven when no symbol is being sent.
GRAY_MAP, 0, 0 = dibit drives sel directly; 1 = sel = {b1, b1^b0} (Gray-to-level map).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
data_in  input  8  byte to transmit.
data_valid  input  1  data_in is valid this cycle.
data_ready  output  1  block can accept a byte this cycle.
sel  output  2  carrier select to the 4-ASK multiplexer; registered.
sym_strobe  output  1  one-cycle pulse in the first cycle each new symbol appears on sel; registered.
busy  output  1  high while in SEND or while the holding register is full.

Behaviour:
- Reset, asynchronous, while rst=1:
  - sel=IDLE_SEL, sym_strobe=0, busy=0.
  - hold_full=0, state=IDLE, per_cnt=0, sym_cnt=0.
  - data_ready=0.
- data_ready = !hold_full && !rst (combinational).
- Accept: data_valid && data_ready at an edge sets hold<=data_in and hold_full<=1.
- Storage: one holding register (hold, hold_full), one shift register sh[7:0], period counter per_cnt, symbol counter sym_cnt (0..3).
- State IDLE:
  - sel=IDLE_SEL.
  - If hold_full at an edge: sh<=hold, hold_full<=0, sel<=map(hold[7:6]), sym_strobe<=1, per_cnt<=0, sym_cnt<=0, go to SEND.
  - Latency: a byte accepted at edge N appears on sel after edge N+1.
- State SEND:
  - per_cnt increments each clock.
  - At per_cnt==SYMBOL_LEN-1 with sym_cnt<3: shift sh left 2, sel<=map(next pair), sym_cnt++, per_cnt<=0, sym_strobe<=1.
  - At per_cnt==SYMBOL_LEN-1 with sym_cnt==3 and hold_full: load the next byte exactly as in IDLE. There is no gap cycle; stay in SEND.
  - At per_cnt==SYMBOL_LEN-1 with sym_cnt==3 and !hold_full: sel<=IDLE_SEL, sym_strobe<=0, go to IDLE.
- sym_strobe is 0 in all other cycles.
- Simultaneous accept and load on the same edge: hold takes the new byte, sh takes the old hold, and hold_full stays 1.
- Accepts while in SEND are legal. At most one byte waits in hold; data_ready deasserts until hold is consumed.
- Throughput: exactly 4*SYMBOL_LEN clocks per byte when streaming.
- SYMBOL_LEN=1: each symbol lasts one clock, and sym_strobe is high every cycle of a continuous stream.
- Reset mid-symbol: immediate return to reset values; the in-flight byte and the held byte are discarded.
- data_in is ignored when data_ready=0.

Test Plan:
- SYMBOL_LEN=4, GRAY_MAP=0, send 0xB4 once -> sel = 10,11,01,00, each for 4 clocks, starting 1 clock after accept. Then IDLE_SEL. sym_strobe pulses 4 times, 4 clocks apart. busy falls with the return to IDLE.
- GRAY_MAP=1, send 0xB4 -> sel = 11,10,01,00.
- Back-to-back 0xB4, 0x1E with data_valid held high -> second byte is accepted while the first is sending. sel = 10,11,01,00,00,01,11,10 with no IDLE cycle between bytes. data_ready is low from the second accept until the second byte loads.
- Backpressure: data_valid held high with 3 bytes queued -> third byte waits until data_ready rises at the first-to-second byte boundary. No byte is lost or duplicated.
- Reset asserted during the 2nd symbol of a byte, with a byte also held -> sel=IDLE_SEL, busy=0 and data_ready=0 immediately; data_ready=1 after release. The next byte sent transmits correctly from its first symbol.
- SYMBOL_LEN=1, send 0xFF then 0x00 -> sel = 11 for 4 clocks then 00 for 4 clocks. sym_strobe is high for all 8 cycles.
